nn_mac_engine: RTL and testbench

Parametrised multi-lane multiply-accumulate execution unit for the NN processor datapath. It generalises the scalar two-ALU chain (ALU1 feeding ALU2) into LANES parallel signed MAC lanes with per-lane accumulators, a two-stage pipeline, valid/ready handshakes on both sides, output saturation and optional ReLU. It sits in the execute stage and is fed by the decode/ID-EX register; results go to write-back or data memory.

---
 rtl/nn_mac_engine.sv | 170 +++++++++++++++++
 tb/tb_nn_mac_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_engine.sv
// nn_mac_engine
//   Multi-lane signed multiply-accumulate unit for the NN execute stage.
//   Stage S1 registers the opcode and a full-precision product per lane;
//   stage S2 applies the opcode to the per-lane accumulators and, for emit
//   opcodes, loads out_data with the saturated (optionally ReLU'd) value.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   in_valid/in_ready command handshake; in_op opcode, in_a/in_b packed lanes
//   out_valid/out_ready result handshake; out_data packed lanes
//   busy              command in flight or result pending
//   sat_flag          sticky per-lane saturation flag (cleared by CLR / RST)
module nn_mac_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_op,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          busy,
    output logic [LANES-1:0]              sat_flag
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_MAC    = 3'd1,
        OP_MUL    = 3'd2,
        OP_CLR    = 3'd3,
        OP_OUT    = 3'd4,
        OP_RELU   = 3'd5,
        OP_OUTCLR = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    localparam int PW = 2*DATA_WIDTH;

    localparam logic [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                          w_stall;
    logic                          w_accept;
    logic                          w_emit;

    logic                          r_s1_valid;
    op_e                           r_s1_op;
    logic signed [PW-1:0]          r_s1_prod  [LANES];

    logic signed [PW-1:0]          w_a_ext    [LANES];
    logic signed [PW-1:0]          w_b_ext    [LANES];
    logic signed [PW-1:0]          w_prod     [LANES];

    logic signed [ACC_WIDTH-1:0]   r_acc      [LANES];
    logic signed [ACC_WIDTH-1:0]   w_acc_nxt  [LANES];
    logic        [ACC_WIDTH:0]     w_pext     [LANES];
    logic        [ACC_WIDTH:0]     w_sum      [LANES];
    logic        [DATA_WIDTH-1:0]  w_sat      [LANES];
    logic        [LANES-1:0]       w_clip;
    logic        [LANES-1:0]       w_flag_nxt;
    logic        [LANES-1:0]       r_sat_flag;

    logic [LANES*DATA_WIDTH-1:0]   w_out_nxt;
    logic [LANES*DATA_WIDTH-1:0]   r_out_data;
    logic                          r_out_valid;

    // A pending, unaccepted result freezes the whole pipeline.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !RST && !w_stall;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            w_a_ext[i] = {{DATA_WIDTH{in_a[i*DATA_WIDTH+DATA_WIDTH-1]}}, in_a[i*DATA_WIDTH +: DATA_WIDTH]};
            w_b_ext[i] = {{DATA_WIDTH{in_b[i*DATA_WIDTH+DATA_WIDTH-1]}}, in_b[i*DATA_WIDTH +: DATA_WIDTH]};
            w_prod[i]  = w_a_ext[i] * w_b_ext[i];
        end
    end

    always_comb begin
        w_acc_nxt  = r_acc;
        w_flag_nxt = r_sat_flag;
        w_out_nxt  = r_out_data;
        w_emit     = r_s1_valid && !w_stall &&
                     (r_s1_op == OP_OUT || r_s1_op == OP_RELU || r_s1_op == OP_OUTCLR);
        for (int unsigned i = 0; i < LANES; i++) begin
            // Sign-extended product and one-bit-wider sum: overflow shows as
            // disagreement between the two top bits.
            w_pext[i] = {{(ACC_WIDTH+1-PW){r_s1_prod[i][PW-1]}}, r_s1_prod[i]};
            w_sum[i]  = {r_acc[i][ACC_WIDTH-1], r_acc[i]} + w_pext[i];
            // Fits in DATA_WIDTH only if all bits from the output sign bit up agree.
            w_clip[i] = (|r_acc[i][ACC_WIDTH-1:DATA_WIDTH-1]) && !(&r_acc[i][ACC_WIDTH-1:DATA_WIDTH-1]);
            w_sat[i]  = w_clip[i] ? (r_acc[i][ACC_WIDTH-1] ? OUT_MIN : OUT_MAX)
                                  : r_acc[i][DATA_WIDTH-1:0];
            if (r_s1_valid && !w_stall) begin
                case (r_s1_op)
                    OP_MAC: begin
                        if (w_sum[i][ACC_WIDTH] != w_sum[i][ACC_WIDTH-1]) begin
                            w_acc_nxt[i]  = w_sum[i][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                            w_flag_nxt[i] = 1'b1;
                        end else begin
                            w_acc_nxt[i]  = w_sum[i][ACC_WIDTH-1:0];
                        end
                    end
                    OP_MUL: w_acc_nxt[i] = w_pext[i][ACC_WIDTH-1:0];
                    OP_CLR: begin
                        w_acc_nxt[i]  = '0;
                        w_flag_nxt[i] = 1'b0;
                    end
                    OP_OUT: begin
                        w_out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = w_sat[i];
                        w_flag_nxt[i] = r_sat_flag[i] | w_clip[i];
                    end
                    OP_RELU: begin
                        w_out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = w_sat[i][DATA_WIDTH-1] ? '0 : w_sat[i];
                        w_flag_nxt[i] = r_sat_flag[i] | w_clip[i];
                    end
                    OP_OUTCLR: begin
                        w_out_nxt[i*DATA_WIDTH +: DATA_WIDTH] = w_sat[i];
                        w_flag_nxt[i] = r_sat_flag[i] | w_clip[i];
                        w_acc_nxt[i]  = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_NOP;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                r_acc[i]     <= '0;
                r_s1_prod[i] <= '0;
            end
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_op <= op_e'(in_op);
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_s1_prod[i] <= w_prod[i];
                end
            end
            r_acc       <= w_acc_nxt;
            r_sat_flag  <= w_flag_nxt;
            r_out_data  <= w_out_nxt;
            // Not stalled means any pending result is being taken this edge;
            // only a fresh emit keeps out_valid high.
            r_out_valid <= w_emit;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sat_flag  = r_sat_flag;
    assign busy      = r_s1_valid || r_out_valid;

endmodule

// File: tb/tb_nn_mac_engine.sv
module tb_nn_mac_engine;

    localparam int DW    = 8;
    localparam int LN    = 4;
    localparam int ACC_W = 16;
    localparam int AMAX  = 2**(ACC_W-1) - 1;
    localparam int AMIN  = -(2**(ACC_W-1));
    localparam int OMAX  = 2**(DW-1) - 1;
    localparam int OMIN  = -(2**(DW-1));

    logic              CLK;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [LN*DW-1:0]  in_a;
    logic [LN*DW-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [LN*DW-1:0]  out_data;
    logic              busy;
    logic [LN-1:0]     sat_flag;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           m_acc [LN];
    logic [LN-1:0] m_flag;
    logic [31:0]  exp_q [$];
    bit           rnd_bp;

    nn_mac_engine #(
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .ACC_WIDTH  (ACC_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LN; i++) m_acc[i] = 0;
        m_flag = '0;
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        bit          emit;
        res  = '0;
        emit = 1'b0;
        for (int i = 0; i < LN; i++) begin
            byte sa;
            byte sb;
            int  p;
            int  v;
            sa = a[i*8 +: 8];
            sb = b[i*8 +: 8];
            p  = int'(sa) * int'(sb);
            case (op)
                3'd1: begin
                    v = m_acc[i] + p;
                    if (v > AMAX) begin v = AMAX; m_flag[i] = 1'b1; end
                    else if (v < AMIN) begin v = AMIN; m_flag[i] = 1'b1; end
                    m_acc[i] = v;
                end
                3'd2: m_acc[i] = p;
                3'd3: begin m_acc[i] = 0; m_flag[i] = 1'b0; end
                3'd4, 3'd5, 3'd6: begin
                    v = m_acc[i];
                    if (v > OMAX) begin v = OMAX; m_flag[i] = 1'b1; end
                    else if (v < OMIN) begin v = OMIN; m_flag[i] = 1'b1; end
                    if (op == 3'd5 && v < 0) v = 0;
                    res[i*8 +: 8] = v[7:0];
                    emit = 1'b1;
                    if (op == 3'd6) m_acc[i] = 0;
                end
                default: ;
            endcase
        end
        if (emit) exp_q.push_back(res);
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        #4;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge CLK); #4; n++;
        end
        chk("send_accept", in_ready, 1'b1);
        if (in_ready === 1'b1) begin
            @(posedge CLK);
            model(op, a, b);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] exp);
        int unsigned n = 0;
        #4;
        while (!(out_valid === 1'b1 && out_ready === 1'b1) && n < 20) begin
            @(negedge CLK); #4; n++;
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk(tag, out_data, exp);
        @(negedge CLK);
    endtask

    task automatic drain(input string tag);
        int unsigned n = 0;
        #4;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 60) begin
            @(negedge CLK); #4; n++;
        end
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_sat_flag"}, sat_flag, m_flag);
        @(negedge CLK);
    endtask

    function automatic logic [7:0] rv();
        case ($urandom_range(0, 5))
            0: return 8'h7F;
            1: return 8'h80;
            2: return 8'h64;
            3: return 8'h9C;
            default: return 8'($urandom);
        endcase
    endfunction

    // Output scoreboard: every transferred result must match the model in order.
    always begin
        @(negedge CLK); #4;
        if (RST === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("out_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        RST = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        out_ready = 1'b1; rnd_bp = 1'b0;
        model_reset();

        // Reset then idle
        @(negedge CLK); @(negedge CLK);
        #1;
        chk("rst_in_ready_low", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_out_data", out_data, 32'h0);
        chk("post_rst_sat_flag", sat_flag, 4'h0);
        chk("post_rst_busy", busy, 1'b0);
        @(negedge CLK);

        // Dot product and two-edge latency
        send(3'd1, 32'h04030201, 32'h08070605);
        send(3'd1, 32'hFFFFFFFF, 32'h02020202);
        send(3'd4, 32'h0, 32'h0);
        #1;
        chk("dot_not_yet_valid", out_valid, 1'b0);
        chk("dot_busy", busy, 1'b1);
        @(negedge CLK); #1;
        chk("dot_valid", out_valid, 1'b1);
        chk("dot_data", out_data, 32'h1E130A03);
        @(negedge CLK);

        // MUL / RELU / OUTCLR / OUT
        send(3'd2, 32'hF90003FD, 32'h01090404);
        send(3'd5, 32'h0, 32'h0);
        expect_out("relu", 32'h00000C00);
        send(3'd6, 32'h0, 32'h0);
        expect_out("outclr", 32'hF9000CF4);
        send(3'd4, 32'h0, 32'h0);
        expect_out("out_after_clr", 32'h00000000);
        chk("relu_sat_flag", sat_flag, 4'h0);

        // Output saturation
        send(3'd1, 32'h64646464, 32'h64646464);
        send(3'd1, 32'h64646464, 32'h64646464);
        send(3'd4, 32'h0, 32'h0);
        expect_out("sat_pos", 32'h7F7F7F7F);
        chk("sat_flag_set", sat_flag, 4'hF);
        send(3'd1, 32'h9C9C9C9C, 32'h64646464);
        send(3'd1, 32'h9C9C9C9C, 32'h64646464);
        send(3'd1, 32'h9C9C9C9C, 32'h64646464);
        send(3'd4, 32'h0, 32'h0);
        expect_out("sat_neg", 32'h80808080);
        send(3'd3, 32'h0, 32'h0);
        drain("clr");
        chk("sat_flag_cleared", sat_flag, 4'h0);

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                send(3'd1, 32'h04030201, 32'h01010101);
                send(3'd4, 32'h0, 32'h0);
                send(3'd1, 32'h05050505, 32'h02020202);
                send(3'd4, 32'h0, 32'h0);
            end
            begin : bp_watch
                int unsigned bn;
                bn = 0;
                #4;
                while (out_valid !== 1'b1 && bn < 20) begin
                    @(negedge CLK); #4; bn++;
                end
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", in_ready, 1'b0);
                    chk("bp_out_valid", out_valid, 1'b1);
                    chk("bp_hold", out_data, 32'h04030201);
                    @(negedge CLK); #4;
                end
                @(negedge CLK);
                out_ready = 1'b1;
            end
        join
        expect_out("bp_second", 32'h0E0D0C0B);
        drain("bp");

        // Reset while OUT sits in S1
        send(3'd1, 32'h01010101, 32'h03030303);
        send(3'd4, 32'h0, 32'h0);
        RST = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("rst_mid_no_valid", out_valid, 1'b0);
            @(negedge CLK);
        end
        send(3'd4, 32'h0, 32'h0);
        expect_out("rst_mid_acc", 32'h00000000);

        // Randomized commands with random output backpressure
        rnd_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3: op = 3'd1;
                4:          op = 3'd2;
                5:          op = 3'd3;
                6, 7:       op = 3'd4;
                8:          op = 3'd5;
                9:          op = 3'd6;
                10:         op = 3'd0;
                default:    op = 3'd7;
            endcase
            a = {rv(), rv(), rv(), rv()};
            b = {rv(), rv(), rv(), rv()};
            send(op, a, b);
            if ($urandom_range(0, 7) == 0) @(negedge CLK);
            if (n % 50 == 49) begin
                rnd_bp = 1'b0;
                out_ready = 1'b1;
                drain("rnd");
                rnd_bp = 1'b1;
            end
        end
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        send(3'd4, 32'h0, 32'h0);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
